// File: rtl/uart_rx.sv
// 8-bit UART receiver (LSB first, 1 stop bit) with resync-after-reset and break handling.
// Define UART_RX_PARITY_EN for 8E1 frames with an even-parity check; the default build is 8N1.
module uart_rx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] RX_data,
    output logic       byte_done,
    output logic       frame_err,
    output logic       parity_err,
    output logic       rx_busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_RESYNC,
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state;
    logic             rx_meta, rx_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             armed;
    logic             par_bad;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    assign par_bad = par_bit ^ (^shift);
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign rx_busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_RESYNC;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            armed     <= 1'b0;
            RX_data   <= '0;
            byte_done <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            byte_done <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                // A full bit period of high must be seen and then confirmed by one more
                // high sample, so a single '1' data bit can never look like idle line.
                S_RESYNC: begin
                    if (!rx_s) begin
                        cnt   <= '0;
                        armed <= 1'b0;
                    end else if (armed) begin
                        state <= S_IDLE;
                        armed <= 1'b0;
                        cnt   <= '0;
                    end else if (cnt == CNT_END) begin
                        armed <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (!rx_s) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                S_START: begin
                    if (cnt == CNT_MID) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= S_IDLE;
                        end else begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == CNT_END) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt == CNT_END) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                        state   <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
                S_STOP: begin
                    if (cnt == CNT_END) begin
                        cnt <= '0;
`ifdef UART_RX_PARITY_EN
                        parity_err <= par_bad;
`endif
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end else begin
                            state <= S_IDLE;
                            if (!par_bad) begin
                                RX_data   <= shift;
                                byte_done <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rx_s) state <= S_IDLE;
                end
                default: state <= S_RESYNC;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: scoreboard of expected bytes popped on each byte_done,
// plus counters of error pulses checked around each scenario.
module tb_uart_rx;
    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int N        = 10;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int LAT = (9 + PAR) * N + N / 2 + 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] RX_data;
    logic       byte_done, frame_err, parity_err, rx_busy;

    int checks = 0, errors = 0;
    int cyc = 0, bd_cnt = 0, fe_cnt = 0, pe_cnt = 0, bd_cyc = 0, f_start = 0;
    int b0, f0, p0;
    logic [7:0] last_data = 8'h00;
    logic [7:0] exp_b;
    logic [7:0] q[$];

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .RX_data   (RX_data),
        .byte_done (byte_done),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor, run at every falling edge.
    task automatic sample();
        if (byte_done === 1'b1) begin
            bd_cnt++;
            bd_cyc = cyc;
            check("byte_expected", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                exp_b = q.pop_front();
                check("byte_data", 32'(RX_data), 32'(exp_b));
                last_data = exp_b;
            end
            check("done_no_err", 32'(frame_err | parity_err), 32'd0);
        end else begin
            check("rx_data_hold", 32'(RX_data), 32'(last_data));
        end
        if (frame_err === 1'b1) fe_cnt++;
        if (parity_err === 1'b1) pe_cnt++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            sample();
            @(posedge clk);
            cyc++;
            if (!rst_n) last_data = 8'h00;
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok);
        rx = 1'b0;
        f_start = cyc;
        tick(N);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(N);
        end
        if (PAR != 0) begin
            rx = par_ok ? ^d : ~^d;
            tick(N);
        end
        rx = stop;
        tick(N);
    endtask

    task automatic send_good(input logic [7:0] d);
        q.push_back(d);
        send_frame(d, 1'b1, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        tick(3);
        check("reset_data", 32'(RX_data), 32'h0);
        check("reset_done", 32'(byte_done), 32'd0);
        check("reset_ferr", 32'(frame_err), 32'd0);
        check("reset_perr", 32'(parity_err), 32'd0);
        check("reset_busy", 32'(rx_busy), 32'd1);
        rst_n = 1'b1;
        tick(2 * N);
        check("resync_idle", 32'(rx_busy), 32'd0);

        // single byte after idle
        b0 = bd_cnt; f0 = fe_cnt;
        send_good(8'h0F);
        tick(3);
        check("t1_count", 32'(bd_cnt - b0), 32'd1);
        check("t1_latency", 32'(bd_cyc - f_start), 32'(LAT));
        check("t1_ferr", 32'(fe_cnt - f0), 32'd0);
        tick(2 * N);
        check("t1_hold", 32'(RX_data), 32'h0F);

        // back-to-back frames, no idle gap
        b0 = bd_cnt;
        send_good(8'hFF);
        send_good(8'hA5);
        tick(3);
        check("t2_count", 32'(bd_cnt - b0), 32'd2);
        check("t2_data", 32'(RX_data), 32'hA5);
        check("t2_queue", 32'(q.size()), 32'd0);

        // 3-clock glitch
        tick(N);
        b0 = bd_cnt; f0 = fe_cnt; p0 = pe_cnt;
        rx = 1'b0;
        tick(3);
        check("t3_busy", 32'(rx_busy), 32'd1);
        rx = 1'b1;
        tick(6);
        check("t3_idle", 32'(rx_busy), 32'd0);
        tick(N);
        check("t3_nobyte", 32'(bd_cnt - b0), 32'd0);
        check("t3_noferr", 32'(fe_cnt - f0), 32'd0);
        check("t3_noperr", 32'(pe_cnt - p0), 32'd0);

        // framing error followed by a long break
        send_good(8'h11);
        tick(N);
        b0 = bd_cnt; f0 = fe_cnt; p0 = pe_cnt;
        rx = 1'b0;
        tick(N * (9 + PAR));
        tick(N * 21);
        rx = 1'b1;
        tick(N);
        check("t4_ferr", 32'(fe_cnt - f0), 32'd1);
        check("t4_keep", 32'(RX_data), 32'h11);
        check("t4_nobyte", 32'(bd_cnt - b0), 32'd0);
        check("t4_noperr", 32'(pe_cnt - p0), 32'd0);
        send_good(8'h3C);
        tick(3);
        check("t4_data", 32'(RX_data), 32'h3C);
        check("t4_count", 32'(bd_cnt - b0), 32'd1);

        // reset during bit 3 of 0x55
        tick(N);
        b0 = bd_cnt;
        exp_b = 8'h55;
        rx = 1'b0;
        tick(N);
        for (int i = 0; i < 3; i++) begin
            rx = exp_b[i];
            tick(N);
        end
        rx = exp_b[3];
        tick(4);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        check("t5_data", 32'(RX_data), 32'h0);
        check("t5_done", 32'(byte_done), 32'd0);
        check("t5_ferr", 32'(frame_err), 32'd0);
        check("t5_perr", 32'(parity_err), 32'd0);
        check("t5_busy", 32'(rx_busy), 32'd1);
        tick(N - 6);
        for (int i = 4; i < 8; i++) begin
            rx = exp_b[i];
            tick(N);
        end
        if (PAR != 0) begin
            rx = ^exp_b;
            tick(N);
        end
        rx = 1'b1;
        tick(N);
        tick(10);
        check("t5_dropped", 32'(bd_cnt - b0), 32'd0);
        send_good(8'h55);
        tick(3);
        check("t5_count", 32'(bd_cnt - b0), 32'd1);
        check("t5_rx", 32'(RX_data), 32'h55);

`ifdef UART_RX_PARITY_EN
        tick(N);
        b0 = bd_cnt; p0 = pe_cnt; f0 = fe_cnt;
        send_frame(8'h01, 1'b1, 1'b0);
        tick(3);
        check("t6_perr", 32'(pe_cnt - p0), 32'd1);
        check("t6_nobyte", 32'(bd_cnt - b0), 32'd0);
        check("t6_keep", 32'(RX_data), 32'h55);
        check("t6_noferr", 32'(fe_cnt - f0), 32'd0);
        send_good(8'h01);
        tick(3);
        check("t6_count", 32'(bd_cnt - b0), 32'd1);
        check("t6_data", 32'(RX_data), 32'h01);
        check("t6_perr_once", 32'(pe_cnt - p0), 32'd1);
`endif

        tick(N);
        check("final_queue", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
